// File: rtl/uart_byte_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver_if
//   Bundles the serial line and the received-byte outputs of the UART byte
//   receiver.
//
//   rx        : raw serial line, idle high (line side -> receiver)
//   rx_data   : last good byte, held until the next good frame
//   rx_valid  : one-cycle pulse, rx_data just updated
//   rx_perror : one-cycle pulse, parity mismatch
//   rx_ferror : one-cycle pulse, stop bit sampled low
//   busy      : receiver is inside a frame
//
//   master : line driver / byte consumer side
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_byte_receiver_if #(
   parameter int N = 8
);
   logic         rx;
   logic [N-1:0] rx_data;
   logic         rx_valid;
   logic         rx_perror;
   logic         rx_ferror;
   logic         busy;

   modport master (
      output rx,
      input  rx_data, rx_valid, rx_perror, rx_ferror, busy
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, rx_perror, rx_ferror, busy
   );
endinterface

// File: rtl/uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver
//   Recovers N-bit bytes (LSB first, optional even parity, one stop bit) from
//   an asynchronous UART line with 16x oversampling. Only good frames update
//   rx_data; parity and framing errors are flagged and leave it untouched.
//
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : uart_byte_receiver_if.slave (rx in; rx_data, rx_valid,
//           rx_perror, rx_ferror, busy out)
// ---------------------------------------------------------------------------
module uart_byte_receiver #(
   parameter int N         = 8,
   parameter int BAUD_DIV  = 27,
   parameter int PARITY_EN = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_byte_receiver_if.slave  bus
);
   localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BW = $clog2(N + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state;
   logic            rx_meta;
   logic            rx_s;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [3:0]      os_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [N-1:0]    shift_reg;
   logic            par_bit;
   logic            parity_ok;

   // Two-flop synchronizer; resets to the idle (high) line level so a reset
   // never looks like a start edge.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   assign tick      = (tick_cnt == TICK_LAST);
   assign parity_ok = (PARITY_EN == 0) || ((^shift_reg ^ par_bit) == 1'b0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         os_cnt        <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         par_bit       <= 1'b0;
         bus.rx_data   <= '0;
         bus.rx_valid  <= 1'b0;
         bus.rx_perror <= 1'b0;
         bus.rx_ferror <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         // Flags are single-cycle pulses unless a branch below raises them.
         bus.rx_valid  <= 1'b0;
         bus.rx_perror <= 1'b0;
         bus.rx_ferror <= 1'b0;

         // Free-running tick divider, re-phased to the detected start edge.
         if (state == IDLE && !rx_s) begin
            tick_cnt <= '0;
         end else if (tick) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + TW'(1);
         end

         // Oversample counter wraps 15 -> 0; state branches override it.
         if (tick) begin
            os_cnt <= os_cnt + 4'd1;
         end

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  os_cnt   <= '0;
                  bus.busy <= 1'b1;
               end
            end

            START: begin
               // Mid start bit: still low means a real frame, else a glitch.
               if (tick && os_cnt == 4'd7) begin
                  if (!rx_s) begin
                     state   <= DATA;
                     os_cnt  <= '0;
                     bit_cnt <= '0;
                  end else begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end
            end

            DATA: begin
               if (tick && os_cnt == 4'd15) begin
                  shift_reg <= {rx_s, shift_reg[N-1:1]};
                  bit_cnt   <= bit_cnt + BW'(1);
                  if (bit_cnt == BIT_LAST) begin
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
                  end
               end
            end

            PARITY: begin
               if (tick && os_cnt == 4'd15) begin
                  par_bit <= rx_s;
                  state   <= STOP;
               end
            end

            STOP: begin
               // Framing error wins over parity; exactly one flag per frame.
               if (tick && os_cnt == 4'd15) begin
                  if (!rx_s) begin
                     bus.rx_ferror <= 1'b1;
                     state         <= WAIT_HIGH;
                  end else begin
                     if (parity_ok) begin
                        bus.rx_data  <= shift_reg;
                        bus.rx_valid <= 1'b1;
                     end else begin
                        bus.rx_perror <= 1'b1;
                     end
                     // Leaving mid stop bit lets a back-to-back start edge
                     // be caught from IDLE.
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end
            end

            WAIT_HIGH: begin
               // A break/held-low line yields one ferror, not a frame stream.
               if (rx_s) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_receiver
//   Drives UART frames into uart_byte_receiver (N=8, BAUD_DIV=4, even parity)
//   and compares the reported events and held byte against a frame-level
//   reference: each sent frame predicts one outcome (good byte, parity error
//   or framing error) queued in send order.
// ---------------------------------------------------------------------------
module tb_uart_byte_receiver;
   localparam int N        = 8;
   localparam int BAUD_DIV = 4;
   localparam int BIT      = 16 * BAUD_DIV;  // clocks per bit period

   typedef struct {
      logic [2:0] flags;  // {valid, perror, ferror}
      logic [7:0] data;
   } ev_t;

   logic clk;
   logic rst_n;

   uart_byte_receiver_if #(.N(N)) bus ();

   uart_byte_receiver #(
      .N        (N),
      .BAUD_DIV (BAUD_DIV),
      .PARITY_EN(1)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_valid  = 0;
   int         n_perr   = 0;
   int         n_ferr   = 0;
   ev_t        exp_q[$];
   ev_t        ev_mon;
   logic [7:0] model_data = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Event monitor: every flag pulse must match the oldest predicted outcome.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_data = 8'h00;
      end else if (bus.rx_valid || bus.rx_perror || bus.rx_ferror) begin
         if (bus.rx_valid)  n_valid++;
         if (bus.rx_perror) n_perr++;
         if (bus.rx_ferror) n_ferr++;
         if (exp_q.size() == 0) begin
            check("unexpected_flag", {29'd0, bus.rx_valid, bus.rx_perror, bus.rx_ferror}, 32'd0);
         end else begin
            ev_mon = exp_q.pop_front();
            check("flags", {29'd0, bus.rx_valid, bus.rx_perror, bus.rx_ferror}, {29'd0, ev_mon.flags});
            if (ev_mon.flags == 3'b100) model_data = ev_mon.data;
            check("rx_data_at_flag", {24'd0, bus.rx_data}, {24'd0, model_data});
         end
      end
   end

   initial begin
      #800us;
      $display("FAIL watchdog simulation did not finish (checks=%0d)", n_checks);
      $fatal(1);
   end

   task automatic send_bit(input logic b);
      bus.rx = b;
      repeat (BIT) @(negedge clk);
   endtask

   // Predicts the frame outcome from the line rules, then drives the frame.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      ev_t e;
      e.data  = d;
      e.flags = !s ? 3'b001 : ((p != ^d) ? 3'b010 : 3'b100);
      exp_q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 3 * BIT && (exp_q.size() != 0 || bus.busy); i++) begin
         @(negedge clk);
         #1;
      end
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_held"}, {24'd0, bus.rx_data}, {24'd0, model_data});
   endtask

   initial begin
      int v0, p0, f0;
      logic [7:0] d;
      logic       perr_i, ferr_i;

      bus.rx = 1'b1;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",   {24'd0, bus.rx_data}, 32'd0);
      check("rst_valid",  {31'd0, bus.rx_valid}, 32'd0);
      check("rst_perror", {31'd0, bus.rx_perror}, 32'd0);
      check("rst_ferror", {31'd0, bus.rx_ferror}, 32'd0);
      check("rst_busy",   {31'd0, bus.busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2 * BIT) @(negedge clk);

      // T1: good frame
      v0 = n_valid;
      send_frame(8'hA5, 1'b0, 1'b1);
      send_bit(1'b1);
      drain("t1");
      check("t1_data", {24'd0, bus.rx_data}, 32'hA5);
      check("t1_valid_count", n_valid - v0, 1);

      // T2: bad parity keeps the previous byte
      p0 = n_perr; v0 = n_valid;
      send_frame(8'h3C, 1'b1, 1'b1);
      send_bit(1'b1);
      drain("t2");
      check("t2_data", {24'd0, bus.rx_data}, 32'hA5);
      check("t2_perr_count", n_perr - p0, 1);
      check("t2_valid_count", n_valid - v0, 0);

      // T3: framing error with a long break, then recovery
      f0 = n_ferr;
      send_frame(8'h0F, 1'b0, 1'b0);
      repeat (20 * BIT) @(negedge clk);
      check("t3_wait_high_busy", {31'd0, bus.busy}, 32'd1);
      repeat (20 * BIT) @(negedge clk);
      check("t3_wait_high_busy_late", {31'd0, bus.busy}, 32'd1);
      send_bit(1'b1);
      send_bit(1'b1);
      check("t3_released_busy", {31'd0, bus.busy}, 32'd0);
      check("t3_ferr_count", n_ferr - f0, 1);
      send_frame(8'h55, 1'b0, 1'b1);
      send_bit(1'b1);
      drain("t3");
      check("t3_data", {24'd0, bus.rx_data}, 32'h55);

      // T4: start glitch of 5 ticks
      bus.rx = 1'b0;
      repeat (10) @(negedge clk);
      check("t4_busy_in_glitch", {31'd0, bus.busy}, 32'd1);
      repeat (10) @(negedge clk);
      bus.rx = 1'b1;
      for (int i = 0; i < 10 * BAUD_DIV && bus.busy; i++) @(negedge clk);
      check("t4_busy_cleared", {31'd0, bus.busy}, 32'd0);
      repeat (2 * BIT) @(negedge clk);
      check("t4_data", {24'd0, bus.rx_data}, 32'h55);

      // T5: back-to-back frames, no idle gap
      v0 = n_valid;
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      send_frame(8'h81, 1'b0, 1'b1);
      send_bit(1'b1);
      drain("t5");
      check("t5_valid_count", n_valid - v0, 3);
      check("t5_data", {24'd0, bus.rx_data}, 32'h81);

      // T6: reset during data bit 4 of 0x77, then resend
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i));
      bus.rx = 1'b1;  // bit 4 of 0x77
      repeat (BIT / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_rst_data",  {24'd0, bus.rx_data}, 32'd0);
      check("t6_rst_flags", {29'd0, bus.rx_valid, bus.rx_perror, bus.rx_ferror}, 32'd0);
      check("t6_rst_busy",  {31'd0, bus.busy}, 32'd0);
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      repeat (2 * BIT) @(negedge clk);
      check("t6_idle_busy", {31'd0, bus.busy}, 32'd0);
      send_frame(8'h12, 1'b0, 1'b1);
      send_bit(1'b1);
      drain("t6");
      check("t6_data", {24'd0, bus.rx_data}, 32'h12);
      check("t6_valid_count", n_valid - v0, 1);
      check("t6_err_count", (n_perr - p0) + (n_ferr - f0), 0);

      // Randomized frames: random bytes, occasional parity/framing errors,
      // random breaks and idle gaps.
      for (int k = 0; k < 24; k++) begin
         d      = 8'($urandom);
         perr_i = ($urandom_range(0, 3) == 0);
         ferr_i = ($urandom_range(0, 7) == 0);
         send_frame(d, (^d) ^ perr_i, !ferr_i);
         if (ferr_i) begin
            repeat ($urandom_range(0, 3) * BIT) @(negedge clk);
            send_bit(1'b1);
         end
         repeat ($urandom_range(0, 2) * BIT) @(negedge clk);
      end
      send_bit(1'b1);
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_byte_receiver.md
# uart_byte_receiver

Serial receiver that recovers 8-bit bytes from an asynchronous UART line (8 data bits, LSB first, optional even parity, 1 stop bit) using 16x oversampling. It sits directly upstream of the two-digit seven-segment driver. Its held `rx_data` bus feeds the driver's `value` input, and `rx_valid` marks when that bus has changed. Line errors are flagged and never reach the display.

## Interface
- `N`, 8: data bits per frame.
- `BAUD_DIV`, 27: clock cycles per oversample tick (50 MHz / (115200·16) ≈ 27); legal range ≥ 2.
- `PARITY_EN`, 1: 1 = even parity bit present, 0 = no parity bit.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `rx`  in  1: raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  N: last correctly received byte, held until the next good frame.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` has just been updated.
- `rx_perror`  out  1: one-cycle pulse on parity mismatch.
- `rx_ferror`  out  1: one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1: high in every state except IDLE.

## Operation
- **Synchronizer.** `rx` passes through 2 flops to form `rx_s`; all logic uses `rx_s` only. Reset value of both flops is 1.
- **Tick generator.** `tick_cnt` counts 0..BAUD_DIV-1. `tick` asserts when `tick_cnt` = BAUD_DIV-1, then the counter wraps. The counter is forced to 0 on IDLE→START.
- **Sample counter.** `os_cnt` is 4 bits and increments on each `tick`. It wraps 15→0.
- **States.**
  - **IDLE:** `busy`=0. When `rx_s`=0, go to START and clear `tick_cnt` and `os_cnt`.
  - **START:** on the tick where `os_cnt`=7 (mid start bit), sample `rx_s`.
    - If 0: go to DATA, clear `os_cnt` and `bit_cnt`.
    - If 1: this is a glitch; return to IDLE with no flags.
  - **DATA:** on each tick with `os_cnt`=15, shift `rx_s` into bit [N-1] of `shift_reg` (shift right, so bits end up LSB first) and increment `bit_cnt`.
    - After N bits, go to PARITY if PARITY_EN=1, otherwise STOP.
  - **PARITY:** at `os_cnt`=15, capture the parity bit into `par_bit`, then go to STOP.
  - **STOP:** at `os_cnt`=15, sample `rx_s`.
    - If 1 and parity is OK (`^shift_reg ^ par_bit` = 0, or PARITY_EN=0): load `rx_data` from `shift_reg`, pulse `rx_valid`, go to IDLE.
    - If 1 and parity is bad: pulse `rx_perror`, leave `rx_data` unchanged, go to IDLE.
    - If 0: pulse `rx_ferror`, leave `rx_data` unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. A break or held-low line therefore produces exactly one `rx_ferror`.
- **Error precedence.** A framing error takes precedence over a parity error; at most one of `rx_valid`/`rx_perror`/`rx_ferror` pulses per frame.
- **Widths.** `bit_cnt` is $clog2(N+1) bits. `tick_cnt` is $clog2(BAUD_DIV) bits.

## Timing
- **Reset values** (async assert, any state): state=IDLE, `rx_data`=0, `rx_valid`=0, `rx_perror`=0, `rx_ferror`=0, `busy`=0, all counters 0, sync flops 1.
- **Reset mid-frame:** the partial byte is discarded and no flag pulses. After release, a new frame is accepted only after `rx_s` has first been seen low again from IDLE.
- **Bit period:** 16·BAUD_DIV cycles. Data bits are sampled 8.5 ticks after the detected start edge plus k·16 ticks, i.e. mid-bit.
- **Latency:** 2 cycles from `rx` to `rx_s`. `rx_valid`/`rx_perror`/`rx_ferror` and the `rx_data` update are registered and appear the cycle after the stop-bit sample tick.
- **Flag alignment:** `rx_data` is stable from the `rx_valid` cycle onward; the downstream driver may latch it on any later edge.
- **Back-to-back frames:** the return to IDLE occurs mid stop bit, so a start edge arriving immediately after the stop bit is caught with no lost frame.
- **Glitch rejection:** a low pulse shorter than 8 ticks is ignored. A line held low continuously from reset is treated as a start.

## Test plan
- **T1, good frame:** BAUD_DIV=4, PARITY_EN=1, send 0xA5 with parity 0 and stop 1 → exactly one `rx_valid` pulse, `rx_data`=0xA5, no error flags, `busy` returns to 0.
- **T2, bad parity:** after T1, send 0x3C with parity bit 1 → one `rx_perror` pulse, no `rx_valid`, `rx_data` remains 0xA5.
- **T3, framing error:** send 0x0F with stop bit 0, hold the line low 40 bit times, then release → exactly one `rx_ferror`; state stays in WAIT_HIGH until release; a following 0x55 frame yields `rx_data`=0x55.
- **T4, start glitch:** drive `rx` low for 20 cycles (5 ticks), then high → no flags, `rx_data` unchanged, `busy` returns to 0 within 10 ticks.
- **T5, back-to-back:** send 0x00, 0xFF, 0x81 with no idle gap → three `rx_valid` pulses with `rx_data`=0x00, 0xFF, 0x81 in order.
- **T6, reset mid-frame:** assert `reset` low during data bit 4 of 0x77, then resend 0x12 → no flags during or after reset, all outputs 0 while in reset; the resent frame yields `rx_data`=0x12 with a single `rx_valid`.
